// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard unit for an in-order pipeline.
// Each in-flight register write gets a scoreboard entry. Entry 0 is the
// instruction in EX; entry STAGES-1 is the oldest, in writeback. Decode
// sources are matched against the entries to pick a forwarding source or to
// request a load-use stall. A saturating counter records stalled advances.
module pipe_hazard_unit #(
   parameter int REG_W       = 5,
   parameter int STAGES      = 3,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 0,
   parameter int CNT_W       = 32,
   localparam int SEL_W      = (STAGES > 2) ? $clog2(STAGES) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              adv,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wen,
   input  logic [REG_W-1:0]  id_dest,
   input  logic              id_load,
   output logic              stall,
   output logic              fwd_a_en,
   output logic [SEL_W-1:0]  fwd_a_sel,
   output logic              fwd_b_en,
   output logic [SEL_W-1:0]  fwd_b_sel,
   output logic [STAGES-1:0] inflight,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Scoreboard entries; index 0 is the youngest.
   logic [STAGES-1:0] ent_vld;
   logic [STAGES-1:0] ent_ld;
   logic [REG_W-1:0]  ent_dest [STAGES];
   logic [CNT_W-1:0]  cnt_q;

   logic              a_hit, a_rdy;
   logic [SEL_W-1:0]  a_idx;
   logic              b_hit, b_rdy;
   logic [SEL_W-1:0]  b_idx;
   logic              issue;

   // Youngest-match search for both sources. The loop walks from oldest to
   // youngest so the last hit, the lowest index, wins. Register 0 never
   // matches because it is hard-wired in the register file.
   always_comb begin
      a_hit = 1'b0;
      a_rdy = 1'b0;
      a_idx = '0;
      b_hit = 1'b0;
      b_rdy = 1'b0;
      b_idx = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (ent_vld[k] && id_rs_used && (id_rs != '0) && (ent_dest[k] == id_rs)) begin
            a_hit = 1'b1;
            a_idx = SEL_W'(k);
            a_rdy = !ent_ld[k] || (k >= LOAD_LAT);
         end
         if (ent_vld[k] && id_rt_used && (id_rt != '0) && (ent_dest[k] == id_rt)) begin
            b_hit = 1'b1;
            b_idx = SEL_W'(k);
            b_rdy = !ent_ld[k] || (k >= LOAD_LAT);
         end
      end
   end

   // Stall and forward decisions. A flush kills the decode instruction, so
   // it can never stall; forwarding is suppressed while stalled because the
   // decode slot will be replayed next cycle anyway.
   always_comb begin
      stall     = id_valid && !flush && ((a_hit && !a_rdy) || (b_hit && !b_rdy));
      fwd_a_en  = a_hit && a_rdy && !stall;
      fwd_b_en  = b_hit && b_rdy && !stall;
      fwd_a_sel = fwd_a_en ? a_idx : '0;
      fwd_b_sel = fwd_b_en ? b_idx : '0;
      issue     = id_valid && id_wen && (id_dest != '0) && !stall && !flush;
   end

   // Scoreboard shift and stall counter; everything holds while adv is low,
   // which also makes a flush wait for the next advance.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ent_vld <= '0;
         ent_ld  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            ent_dest[k] <= '0;
         end
         cnt_q <= '0;
      end else if (adv) begin
         for (int k = 1; k < STAGES; k++) begin
            ent_vld[k]  <= ent_vld[k-1] && !(flush && ((k - 1) < FLUSH_DEPTH));
            ent_ld[k]   <= ent_ld[k-1];
            ent_dest[k] <= ent_dest[k-1];
         end
         ent_vld[0]  <= issue;
         ent_ld[0]   <= issue && id_load;
         ent_dest[0] <= id_dest;
         if (stall && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign inflight  = ent_vld;
   assign stall_cnt = cnt_q;

endmodule
